// File: rtl/proc_ctrl_pkg.sv
// Shared encodings for the processor control FSM: state type, opcode and
// funct constants, and the I-type opcode to ALU function mapping.
package proc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXE    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_NOP   = 6'd63;

    localparam logic [5:0] FUNCT_SLL = 6'h00;
    localparam logic [5:0] FUNCT_SRL = 6'h02;

    localparam logic [5:0] ALU_ADD = 6'h20;
    localparam logic [5:0] ALU_SLT = 6'h2A;
    localparam logic [5:0] ALU_AND = 6'h24;
    localparam logic [5:0] ALU_OR  = 6'h25;

    function automatic logic [5:0] itype_alu_code(input logic [5:0] op);
        logic [5:0] code;
        case (op)
            OP_ADDI: code = ALU_ADD;
            OP_SLTI: code = ALU_SLT;
            OP_ANDI: code = ALU_AND;
            OP_ORI:  code = ALU_OR;
            default: code = 6'h00;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/op_decoder.sv
// Purely combinational instruction decoder: ALU function, operand-2 source
// selects, immediate extension mode and legality of the incoming opcode.
module op_decoder
    import proc_ctrl_pkg::*;
(
    input  logic [5:0] i_opCode,
    input  logic [5:0] i_funct,
    output logic [5:0] o_aluCode,
    output logic       o_immSel,
    output logic       o_shamtSel,
    output logic       o_signExt,
    output logic       o_legal,
    output logic       o_isNop
);

    always_comb begin
        o_aluCode  = 6'h00;
        o_immSel   = 1'b0;
        o_shamtSel = 1'b0;
        o_signExt  = 1'b0;
        o_legal    = 1'b0;
        o_isNop    = 1'b0;
        case (i_opCode)
            OP_RTYPE: begin
                o_aluCode  = i_funct;
                o_shamtSel = (i_funct == FUNCT_SLL) || (i_funct == FUNCT_SRL);
                o_legal    = 1'b1;
            end
            OP_ADDI, OP_SLTI: begin
                o_aluCode = itype_alu_code(i_opCode);
                o_immSel  = 1'b1;
                o_signExt = 1'b1;
                o_legal   = 1'b1;
            end
            OP_ANDI, OP_ORI: begin
                o_aluCode = itype_alu_code(i_opCode);
                o_immSel  = 1'b1;
                o_legal   = 1'b1;
            end
            OP_NOP: begin
                o_isNop = 1'b1;
            end
            default: begin
                o_legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/proc_control_fsm.sv
// Control FSM: fetches an instruction, reads operands from the register file,
// waits ALU_LAT cycles in EXE, then writes back, with ack timeouts on both RF phases.
module proc_control_fsm
    import proc_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ALU_LAT     = 1,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ENABLE,
    input  logic                  INSTR_VALID,
    input  logic [5:0]            OpCode,
    input  logic [5:0]            Funct,
    input  logic [4:0]            Shamt,
    input  logic [15:0]           Imm,
    input  logic [DATA_WIDTH-1:0] DATA_R1,
    input  logic [DATA_WIDTH-1:0] DATA_R2,
    input  logic                  RF_ACK,
    output logic                  READ,
    output logic                  WRITE,
    output logic [DATA_WIDTH-1:0] ALU_OP1,
    output logic [DATA_WIDTH-1:0] ALU_OP2,
    output logic [5:0]            ALU_Code,
    output logic                  INSTR_DONE,
    output logic                  ILLEGAL,
    output logic                  TIMEOUT,
    output logic                  BUSY
);

    localparam int               ACK_CW   = $clog2(ACK_TIMEOUT + 1);
    localparam logic [ACK_CW-1:0] ACK_LAST = ACK_CW'(ACK_TIMEOUT - 1);
    localparam logic [3:0]        EXE_LOAD = 4'(ALU_LAT);

    state_t                r_state;
    state_t                w_stateNext;
    logic                  r_read;
    logic                  r_write;
    logic                  r_done;
    logic                  r_illegal;
    logic                  r_timeout;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_aluOp1;
    logic [DATA_WIDTH-1:0] r_aluOp2;
    logic [5:0]            r_aluCode;
    logic [3:0]            r_exeCnt;
    logic [3:0]            w_exeCntNext;
    logic [ACK_CW-1:0]     r_ackCnt;
    logic [ACK_CW-1:0]     w_ackCntNext;

    logic [4:0]            r_shamt;
    logic [15:0]           r_imm;
    logic [5:0]            r_decCode;
    logic                  r_immSel;
    logic                  r_shamtSel;
    logic                  r_signExt;

    logic [5:0]            w_decCode;
    logic                  w_decImmSel;
    logic                  w_decShamtSel;
    logic                  w_decSignExt;
    logic                  w_decLegal;
    logic                  w_decNop;

    logic                  w_readNext;
    logic                  w_writeNext;
    logic                  w_doneNext;
    logic                  w_illegalNext;
    logic                  w_timeoutNext;
    logic                  w_accept;
    logic                  w_loadAlu;
    logic [DATA_WIDTH-1:0] w_immExt;
    logic [DATA_WIDTH-1:0] w_op2;

    op_decoder u_decoder (
        .i_opCode   (OpCode),
        .i_funct    (Funct),
        .o_aluCode  (w_decCode),
        .o_immSel   (w_decImmSel),
        .o_shamtSel (w_decShamtSel),
        .o_signExt  (w_decSignExt),
        .o_legal    (w_decLegal),
        .o_isNop    (w_decNop)
    );

    // Decode is resolved at acceptance; only the selected operand-2 source is muxed later.
    assign w_immExt = r_signExt ? DATA_WIDTH'($signed(r_imm)) : DATA_WIDTH'(r_imm);
    assign w_op2    = r_shamtSel ? DATA_WIDTH'(r_shamt) : (r_immSel ? w_immExt : DATA_R2);

    always_comb begin
        w_stateNext   = r_state;
        w_readNext    = 1'b0;
        w_writeNext   = 1'b0;
        w_doneNext    = 1'b0;
        w_illegalNext = 1'b0;
        w_timeoutNext = 1'b0;
        w_accept      = 1'b0;
        w_loadAlu     = 1'b0;
        w_exeCntNext  = r_exeCnt;
        w_ackCntNext  = '0;
        case (r_state)
            S_IDLE: begin
                if (ENABLE) begin
                    w_stateNext = S_FETCH;
                end
            end
            S_FETCH: begin
                if (!ENABLE) begin
                    w_stateNext = S_IDLE;
                end else if (INSTR_VALID) begin
                    if (w_decNop) begin
                        w_doneNext = 1'b1;
                    end else if (w_decLegal) begin
                        w_accept    = 1'b1;
                        w_readNext  = 1'b1;
                        w_stateNext = S_DECODE;
                    end else begin
                        w_illegalNext = 1'b1;
                    end
                end
            end
            S_DECODE: begin
                if (RF_ACK) begin
                    w_loadAlu    = 1'b1;
                    w_exeCntNext = EXE_LOAD;
                    w_stateNext  = S_EXE;
                end else if (r_ackCnt == ACK_LAST) begin
                    w_timeoutNext = 1'b1;
                    w_stateNext   = S_FETCH;
                end else begin
                    w_readNext   = 1'b1;
                    w_ackCntNext = r_ackCnt + ACK_CW'(1);
                end
            end
            S_EXE: begin
                if (r_exeCnt <= 4'd1) begin
                    w_exeCntNext = 4'd0;
                    w_writeNext  = 1'b1;
                    w_stateNext  = S_WB;
                end else begin
                    w_exeCntNext = r_exeCnt - 4'd1;
                end
            end
            S_WB: begin
                if (RF_ACK) begin
                    w_doneNext  = 1'b1;
                    w_stateNext = S_FETCH;
                end else if (r_ackCnt == ACK_LAST) begin
                    w_timeoutNext = 1'b1;
                    w_stateNext   = S_FETCH;
                end else begin
                    w_writeNext  = 1'b1;
                    w_ackCntNext = r_ackCnt + ACK_CW'(1);
                end
            end
            default: begin
                w_stateNext = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state    <= S_FETCH;
            r_read     <= 1'b0;
            r_write    <= 1'b0;
            r_done     <= 1'b0;
            r_illegal  <= 1'b0;
            r_timeout  <= 1'b0;
            r_busy     <= 1'b0;
            r_aluOp1   <= '0;
            r_aluOp2   <= '0;
            r_aluCode  <= '0;
            r_exeCnt   <= '0;
            r_ackCnt   <= '0;
            r_shamt    <= '0;
            r_imm      <= '0;
            r_decCode  <= '0;
            r_immSel   <= 1'b0;
            r_shamtSel <= 1'b0;
            r_signExt  <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_read    <= w_readNext;
            r_write   <= w_writeNext;
            r_done    <= w_doneNext;
            r_illegal <= w_illegalNext;
            r_timeout <= w_timeoutNext;
            r_busy    <= (w_stateNext != S_FETCH) && (w_stateNext != S_IDLE);
            r_exeCnt  <= w_exeCntNext;
            r_ackCnt  <= w_ackCntNext;
            if (w_accept) begin
                r_shamt    <= Shamt;
                r_imm      <= Imm;
                r_decCode  <= w_decCode;
                r_immSel   <= w_decImmSel;
                r_shamtSel <= w_decShamtSel;
                r_signExt  <= w_decSignExt;
            end
            if (w_loadAlu) begin
                r_aluOp1  <= DATA_R1;
                r_aluOp2  <= w_op2;
                r_aluCode <= r_decCode;
            end
        end
    end

    assign READ       = r_read;
    assign WRITE      = r_write;
    assign ALU_OP1    = r_aluOp1;
    assign ALU_OP2    = r_aluOp2;
    assign ALU_Code   = r_aluCode;
    assign INSTR_DONE = r_done;
    assign ILLEGAL    = r_illegal;
    assign TIMEOUT    = r_timeout;
    assign BUSY       = r_busy;

endmodule

// File: tb/tb_proc_control_fsm.sv
// Randomized and directed bench for proc_control_fsm, checked against a
// behavioural instruction-level model of the control sequence.
module tb_proc_control_fsm;

    localparam int DW  = 32;
    localparam int LAT = 1;
    localparam int TMO = 64;

    logic          CLK;
    logic          RST;
    logic          ENABLE;
    logic          INSTR_VALID;
    logic [5:0]    OpCode;
    logic [5:0]    Funct;
    logic [4:0]    Shamt;
    logic [15:0]   Imm;
    logic [DW-1:0] DATA_R1;
    logic [DW-1:0] DATA_R2;
    logic          RF_ACK;
    logic          READ;
    logic          WRITE;
    logic [DW-1:0] ALU_OP1;
    logic [DW-1:0] ALU_OP2;
    logic [5:0]    ALU_Code;
    logic          INSTR_DONE;
    logic          ILLEGAL;
    logic          TIMEOUT;
    logic          BUSY;

    int checks   = 0;
    int failures = 0;

    int         obsLat;
    int         obsToCyc;
    int         obsReadCyc;
    int         obsWriteCyc;
    bit         obsTo;
    bit         obsToRead;
    bit         obsToBusy;
    bit         obsOverlap;
    bit         obsBusy1;
    bit         obsIll;
    logic [5:0] obsCode1;

    logic [5:0]  lastCode;
    logic [31:0] lastOp1;
    logic [31:0] lastOp2;

    proc_control_fsm #(
        .DATA_WIDTH  (DW),
        .ALU_LAT     (LAT),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ENABLE      (ENABLE),
        .INSTR_VALID (INSTR_VALID),
        .OpCode      (OpCode),
        .Funct       (Funct),
        .Shamt       (Shamt),
        .Imm         (Imm),
        .DATA_R1     (DATA_R1),
        .DATA_R2     (DATA_R2),
        .RF_ACK      (RF_ACK),
        .READ        (READ),
        .WRITE       (WRITE),
        .ALU_OP1     (ALU_OP1),
        .ALU_OP2     (ALU_OP2),
        .ALU_Code    (ALU_Code),
        .INSTR_DONE  (INSTR_DONE),
        .ILLEGAL     (ILLEGAL),
        .TIMEOUT     (TIMEOUT),
        .BUSY        (BUSY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Instruction-level reference model
    function automatic bit model_legal(input logic [5:0] op);
        return (op == 6'h00) || (op == 6'h08) || (op == 6'h0A) || (op == 6'h0C) || (op == 6'h0D);
    endfunction

    function automatic logic [5:0] model_code(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00:   return fn;
            6'h08:   return 6'h20;
            6'h0A:   return 6'h2A;
            6'h0C:   return 6'h24;
            6'h0D:   return 6'h25;
            default: return 6'h00;
        endcase
    endfunction

    function automatic logic [31:0] model_op2(input logic [5:0] op, input logic [5:0] fn,
                                              input logic [4:0] sh, input logic [15:0] im,
                                              input logic [31:0] r2);
        int sv;
        if (op == 6'h00) begin
            if (fn == 6'h00 || fn == 6'h02) return 32'(sh);
            return r2;
        end
        if (op == 6'h08 || op == 6'h0A) begin
            sv = int'($signed(im));
            return sv;
        end
        return 32'(im);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drives one instruction and services the register-file handshake; results land in obs*.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                             input logic [15:0] im, input logic [31:0] r1, input logic [31:0] r2,
                             input int dDec, input int dWb, input bit dropEn, input bit exeNoise);
        int cyc;
        bit finished;
        cyc = 0;
        finished = 1'b0;
        obsLat = 0; obsToCyc = 0; obsReadCyc = 0; obsWriteCyc = 0;
        obsTo = 0; obsToRead = 0; obsToBusy = 0; obsOverlap = 0; obsBusy1 = 0; obsIll = 0;
        obsCode1 = '0;
        ENABLE = 1'b1;
        INSTR_VALID = 1'b1;
        OpCode = op; Funct = fn; Shamt = sh; Imm = im;
        DATA_R1 = r1; DATA_R2 = r2;
        RF_ACK = 1'b0;
        while (!finished && cyc < 400) begin
            tick();
            cyc++;
            if (cyc == 1) begin
                INSTR_VALID = 1'b0;
                obsBusy1 = BUSY;
                obsCode1 = ALU_Code;
                OpCode = 6'($urandom); Funct = 6'($urandom);
                Shamt = 5'($urandom); Imm = 16'($urandom);
            end
            if (cyc == 2 && dropEn) ENABLE = 1'b0;
            if (READ && WRITE) obsOverlap = 1'b1;
            if (ILLEGAL) obsIll = 1'b1;
            if (INSTR_DONE) begin
                obsLat = cyc;
                finished = 1'b1;
            end
            if (TIMEOUT) begin
                obsTo = 1'b1; obsToCyc = cyc; obsToRead = READ; obsToBusy = BUSY;
                finished = 1'b1;
            end
            RF_ACK = 1'b0;
            if (READ) begin
                obsReadCyc++;
                RF_ACK = (obsReadCyc > dDec);
            end else if (WRITE) begin
                obsWriteCyc++;
                RF_ACK = (obsWriteCyc > dWb);
            end else if (exeNoise && !finished) begin
                RF_ACK = 1'($urandom_range(0, 1));
            end
        end
        RF_ACK = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0; ENABLE = 1'b0; INSTR_VALID = 1'b0; RF_ACK = 1'b0;
        OpCode = '0; Funct = '0; Shamt = '0; Imm = '0; DATA_R1 = '0; DATA_R2 = '0;
        tick();
        tick();
        checks++;
        if ({READ, WRITE, INSTR_DONE, ILLEGAL, TIMEOUT, BUSY} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL reset_strobes: got %b expected 000000",
                     {READ, WRITE, INSTR_DONE, ILLEGAL, TIMEOUT, BUSY});
        end
        checks++;
        if ({ALU_Code, ALU_OP1, ALU_OP2} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_alu: got code=%h op1=%h op2=%h expected all 0",
                     ALU_Code, ALU_OP1, ALU_OP2);
        end
        RST = 1'b1;
        ENABLE = 1'b1;
        lastCode = '0; lastOp1 = '0; lastOp2 = '0;
    endtask

    task automatic test_addi();
        run_instr(6'h08, 6'h3F, 5'd3, 16'hFFFF, 32'd5, 32'h1234_5678, 0, 0, 1'b0, 1'b0);
        checks++;
        if (obsLat !== LAT + 3) begin
            failures++;
            $display("[TB] FAIL addi_latency: got %0d expected %0d", obsLat, LAT + 3);
        end
        checks++;
        if (ALU_Code !== 6'h20) begin
            failures++;
            $display("[TB] FAIL addi_code: got %h expected 20", ALU_Code);
        end
        checks++;
        if (ALU_OP2 !== 32'hFFFF_FFFF) begin
            failures++;
            $display("[TB] FAIL addi_op2: got %h expected ffffffff", ALU_OP2);
        end
        checks++;
        if (ALU_OP1 !== 32'd5) begin
            failures++;
            $display("[TB] FAIL addi_op1: got %h expected 5", ALU_OP1);
        end
        checks++;
        if (obsBusy1 !== 1'b1 || obsCode1 !== 6'h00) begin
            failures++;
            $display("[TB] FAIL addi_decode_view: got busy=%b code=%h expected busy=1 code=00",
                     obsBusy1, obsCode1);
        end
        lastCode = 6'h20; lastOp1 = 32'd5; lastOp2 = 32'hFFFF_FFFF;
    endtask

    task automatic test_shift();
        logic [31:0] r1;
        logic [31:0] r2;
        r1 = $urandom; r2 = $urandom;
        run_instr(6'h00, 6'h00, 5'd7, 16'($urandom), r1, r2, 0, 0, 1'b0, 1'b1);
        checks++;
        if (ALU_OP2 !== 32'd7 || ALU_OP1 !== r1 || ALU_Code !== 6'h00) begin
            failures++;
            $display("[TB] FAIL sll_operands: got op1=%h op2=%h code=%h expected op1=%h op2=7 code=00",
                     ALU_OP1, ALU_OP2, ALU_Code, r1);
        end
        r1 = $urandom; r2 = $urandom;
        run_instr(6'h00, 6'h20, 5'd9, 16'($urandom), r1, r2, 0, 0, 1'b0, 1'b0);
        checks++;
        if (ALU_OP2 !== r2 || ALU_OP1 !== r1 || ALU_Code !== 6'h20) begin
            failures++;
            $display("[TB] FAIL add_operands: got op1=%h op2=%h code=%h expected op1=%h op2=%h code=20",
                     ALU_OP1, ALU_OP2, ALU_Code, r1, r2);
        end
        lastCode = 6'h20; lastOp1 = r1; lastOp2 = r2;
    endtask

    task automatic test_nop_illegal();
        INSTR_VALID = 1'b1; OpCode = 6'd63; RF_ACK = 1'b1;
        tick();
        checks++;
        if (INSTR_DONE !== 1'b1 || READ !== 1'b0 || BUSY !== 1'b0) begin
            failures++;
            $display("[TB] FAIL nop_pulse: got done=%b read=%b busy=%b expected 1 0 0",
                     INSTR_DONE, READ, BUSY);
        end
        INSTR_VALID = 1'b0; RF_ACK = 1'b0;
        tick();
        checks++;
        if (INSTR_DONE !== 1'b0 || READ !== 1'b0) begin
            failures++;
            $display("[TB] FAIL nop_one_cycle: got done=%b read=%b expected 0 0", INSTR_DONE, READ);
        end
        INSTR_VALID = 1'b1; OpCode = 6'h23;
        tick();
        checks++;
        if (ILLEGAL !== 1'b1 || READ !== 1'b0 || INSTR_DONE !== 1'b0) begin
            failures++;
            $display("[TB] FAIL illegal_pulse: got ill=%b read=%b done=%b expected 1 0 0",
                     ILLEGAL, READ, INSTR_DONE);
        end
        INSTR_VALID = 1'b0;
        tick();
        checks++;
        if (ILLEGAL !== 1'b0 || READ !== 1'b0 || WRITE !== 1'b0 || ALU_Code !== lastCode) begin
            failures++;
            $display("[TB] FAIL illegal_after: got ill=%b read=%b write=%b code=%h expected 0 0 0 code=%h",
                     ILLEGAL, READ, WRITE, ALU_Code, lastCode);
        end
    endtask

    task automatic test_timeout();
        run_instr(6'h0D, 6'h00, 5'd0, 16'h8001, 32'hAAAA_0000, 32'h0, 100000, 0, 1'b0, 1'b0);
        checks++;
        if (obsTo !== 1'b1 || obsToCyc !== TMO + 1) begin
            failures++;
            $display("[TB] FAIL timeout_cycle: got seen=%b cycle=%0d expected seen=1 cycle=%0d",
                     obsTo, obsToCyc, TMO + 1);
        end
        checks++;
        if (obsToRead !== 1'b0 || obsToBusy !== 1'b0 || obsLat !== 0 || obsReadCyc !== TMO) begin
            failures++;
            $display("[TB] FAIL timeout_state: got read=%b busy=%b done_at=%0d read_cycles=%0d expected 0 0 0 %0d",
                     obsToRead, obsToBusy, obsLat, obsReadCyc, TMO);
        end
        checks++;
        if (ALU_Code !== lastCode || ALU_OP1 !== lastOp1 || ALU_OP2 !== lastOp2) begin
            failures++;
            $display("[TB] FAIL timeout_alu_hold: got code=%h op1=%h op2=%h expected %h %h %h",
                     ALU_Code, ALU_OP1, ALU_OP2, lastCode, lastOp1, lastOp2);
        end
        run_instr(6'h0D, 6'h00, 5'd0, 16'h8001, 32'h1, 32'h0, 0, 0, 1'b0, 1'b0);
        checks++;
        if (obsLat !== LAT + 3 || ALU_OP2 !== 32'h0000_8001 || ALU_Code !== 6'h25) begin
            failures++;
            $display("[TB] FAIL after_timeout_ori: got lat=%0d op2=%h code=%h expected %0d 00008001 25",
                     obsLat, ALU_OP2, ALU_Code, LAT + 3);
        end
        lastCode = 6'h25; lastOp1 = 32'h1; lastOp2 = 32'h0000_8001;
    endtask

    task automatic test_reset_abort();
        int cyc;
        int doneCount;
        bit sawWrite;
        sawWrite = 1'b0;
        cyc = 0;
        ENABLE = 1'b1; INSTR_VALID = 1'b1; OpCode = 6'h0A; Funct = 6'h00; Imm = 16'h0010;
        DATA_R1 = 32'h77; RF_ACK = 1'b0;
        while (!sawWrite && cyc < 20) begin
            tick();
            cyc++;
            INSTR_VALID = 1'b0;
            sawWrite = WRITE;
            RF_ACK = READ;
        end
        checks++;
        if (sawWrite !== 1'b1) begin
            failures++;
            $display("[TB] FAIL abort_reach_wb: got write_seen=%b expected 1", sawWrite);
        end
        RF_ACK = 1'b0;
        RST = 1'b0;
        tick();
        checks++;
        if ({READ, WRITE, INSTR_DONE, ILLEGAL, TIMEOUT, BUSY} !== 6'b0 ||
            {ALU_Code, ALU_OP1, ALU_OP2} !== '0) begin
            failures++;
            $display("[TB] FAIL abort_outputs: got strobes=%b code=%h op1=%h op2=%h expected all 0",
                     {READ, WRITE, INSTR_DONE, ILLEGAL, TIMEOUT, BUSY}, ALU_Code, ALU_OP1, ALU_OP2);
        end
        RST = 1'b1;
        RF_ACK = 1'b1;
        doneCount = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (INSTR_DONE || WRITE || TIMEOUT) doneCount++;
        end
        RF_ACK = 1'b0;
        checks++;
        if (doneCount !== 0) begin
            failures++;
            $display("[TB] FAIL abort_no_done: got %0d stray pulses expected 0", doneCount);
        end
        lastCode = '0; lastOp1 = '0; lastOp2 = '0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1;
        r1 = $urandom;
        run_instr(6'h0C, 6'h00, 5'd0, 16'hF0F0, r1, 32'h0, 3, 3, 1'b0, 1'b0);
        checks++;
        if (obsLat !== LAT + 9 || obsReadCyc !== 4 || obsWriteCyc !== 4 || obsOverlap) begin
            failures++;
            $display("[TB] FAIL b2b_first: got lat=%0d rd=%0d wr=%0d ovl=%b expected %0d 4 4 0",
                     obsLat, obsReadCyc, obsWriteCyc, obsOverlap, LAT + 9);
        end
        checks++;
        if (ALU_OP2 !== 32'h0000_F0F0 || ALU_Code !== 6'h24 || ALU_OP1 !== r1) begin
            failures++;
            $display("[TB] FAIL b2b_andi: got op1=%h op2=%h code=%h expected %h 0000f0f0 24",
                     ALU_OP1, ALU_OP2, ALU_Code, r1);
        end
        run_instr(6'h00, 6'h02, 5'd31, 16'h0, 32'h5, 32'h9, 3, 3, 1'b1, 1'b1);
        checks++;
        if (obsLat !== LAT + 9 || obsCode1 !== 6'h24 || ALU_OP2 !== 32'd31 || ALU_Code !== 6'h02) begin
            failures++;
            $display("[TB] FAIL b2b_second: got lat=%0d held=%h op2=%h code=%h expected %0d 24 1f 02",
                     obsLat, obsCode1, ALU_OP2, ALU_Code, LAT + 9);
        end
        lastCode = 6'h02; lastOp1 = 32'h5; lastOp2 = 32'd31;
        INSTR_VALID = 1'b1; OpCode = 6'h08; Imm = 16'h1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (READ !== 1'b0 || BUSY !== 1'b0) begin
                failures++;
                $display("[TB] FAIL idle_ignore[%0d]: got read=%b busy=%b expected 0 0", i, READ, BUSY);
            end
        end
        INSTR_VALID = 1'b0;
        ENABLE = 1'b1;
        tick();
        run_instr(6'h08, 6'h00, 5'd0, 16'h0002, 32'h10, 32'h0, 0, 0, 1'b0, 1'b0);
        checks++;
        if (obsLat !== LAT + 3 || ALU_OP2 !== 32'd2) begin
            failures++;
            $display("[TB] FAIL reenable: got lat=%0d op2=%h expected %0d 2", obsLat, ALU_OP2, LAT + 3);
        end
        lastCode = 6'h20; lastOp1 = 32'h10; lastOp2 = 32'd2;
    endtask

    task automatic test_random();
        logic [5:0]  legalOps [5];
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  sh;
        logic [15:0] im;
        logic [31:0] r1;
        logic [31:0] r2;
        int          dDec;
        int          dWb;
        int          tries;
        legalOps = '{6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D};
        for (int n = 0; n < 24; n++) begin
            op = legalOps[$urandom_range(0, 4)];
            case ($urandom_range(0, 3))
                0:       fn = 6'h00;
                1:       fn = 6'h02;
                default: fn = 6'($urandom);
            endcase
            sh = 5'($urandom); im = 16'($urandom); r1 = $urandom; r2 = $urandom;
            dDec = $urandom_range(0, 4); dWb = $urandom_range(0, 4);
            run_instr(op, fn, sh, im, r1, r2, dDec, dWb, 1'b0, 1'($urandom_range(0, 1)));
            checks++;
            if (obsLat !== LAT + 3 + dDec + dWb || obsOverlap || obsCode1 !== lastCode) begin
                failures++;
                $display("[TB] FAIL rand_seq[%0d]: got lat=%0d ovl=%b held=%h expected %0d 0 %h",
                         n, obsLat, obsOverlap, obsCode1, LAT + 3 + dDec + dWb, lastCode);
            end
            checks++;
            if (ALU_Code !== model_code(op, fn) || ALU_OP1 !== r1 ||
                ALU_OP2 !== model_op2(op, fn, sh, im, r2)) begin
                failures++;
                $display("[TB] FAIL rand_alu[%0d]: op=%h got code=%h op1=%h op2=%h expected %h %h %h",
                         n, op, ALU_Code, ALU_OP1, ALU_OP2, model_code(op, fn), r1,
                         model_op2(op, fn, sh, im, r2));
            end
            lastCode = model_code(op, fn); lastOp1 = r1; lastOp2 = model_op2(op, fn, sh, im, r2);
            if (n % 6 == 5) begin
                tries = 0;
                op = 6'($urandom);
                while ((model_legal(op) || op == 6'd63) && tries < 50) begin
                    op = 6'($urandom);
                    tries++;
                end
                INSTR_VALID = 1'b1; OpCode = op;
                tick();
                INSTR_VALID = 1'b0;
                checks++;
                if (ILLEGAL !== 1'b1 || READ !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL rand_illegal[%0d]: op=%h got ill=%b read=%b expected 1 0",
                             n, op, ILLEGAL, READ);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_shift();
        test_nop_illegal();
        test_timeout();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/proc_control_fsm.md
PROC_CONTROL_FSM -- requirements
Module: proc_control_fsm

Interface
REQ-001 Parameter DATA_WIDTH, 32, operand/data width; SHALL be >= 16.
REQ-002 Parameter ALU_LAT, 1, cycles spent in EXE before writeback; range 1..15.
REQ-003 Parameter ACK_TIMEOUT, 64, maximum cycles waited for RF_ACK before abort.
REQ-004 Clock and reset are CLK and RST: one clock; reset is synchronous and active-low.
REQ-005 Input ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-low reset.
- ENABLE  in  1  allows FETCH to accept instructions.
- INSTR_VALID  in  1  OpCode/Funct/Shamt/Imm are valid.
- OpCode, Funct  in  6  instruction fields.
- Shamt  in  5  shift amount.
- Imm  in  16  immediate.
- DATA_R1, DATA_R2  in  DATA_WIDTH  register-file read data.
- RF_ACK  in  1  register file completed the current read or write.
REQ-006 Output ports:
- READ, WRITE  out  1  register-file strobes.
- ALU_OP1, ALU_OP2  out  DATA_WIDTH  ALU operands.
- ALU_Code  out  6  ALU function.
- INSTR_DONE, ILLEGAL, TIMEOUT  out  1  one-cycle status pulses.
- BUSY  out  1  high when state is not FETCH or IDLE.

Function
REQ-007 States SHALL be IDLE, FETCH, DECODE, EXE and WB; all outputs SHALL be registered.
REQ-008 FETCH with ENABLE=0 SHALL go to IDLE; IDLE with ENABLE=1 SHALL go to FETCH.
REQ-009 FETCH with INSTR_VALID=1 and OpCode=63 (NOP) SHALL stay in FETCH, pulse INSTR_DONE, and SHALL NOT assert READ.
REQ-010 FETCH with INSTR_VALID=1, a legal non-NOP OpCode and ENABLE=1:
- latch all instruction fields;
- set READ=1 in the next cycle;
- enter DECODE.
REQ-011 FETCH with an illegal OpCode SHALL pulse ILLEGAL, stay in FETCH, and leave READ/WRITE at 0.
REQ-012 Legal opcodes:
- 0x00 R-type;
- 0x08 addi maps to ALU_Code 0x20, sign-extended Imm;
- 0x0A slti maps to 0x2A, sign-extended Imm;
- 0x0C andi maps to 0x24, zero-extended Imm;
- 0x0D ori maps to 0x25, zero-extended Imm.
REQ-013 R-type decode:
- ALU_Code = latched Funct; ALU_OP1 = DATA_R1.
- Funct 0x00 (sll) and 0x02 (srl): ALU_OP2 = Shamt zero-extended to DATA_WIDTH.
- Other R-type Funct values: ALU_OP2 = DATA_R2.
REQ-014 I-type decode: ALU_OP1 = DATA_R1; ALU_OP2 = immediate extended per REQ-012.
REQ-015 DECODE SHALL hold READ=1 until RF_ACK=1 is sampled. In that cycle it SHALL:
- register ALU_OP1, ALU_OP2 and ALU_Code;
- clear READ;
- load the EXE counter with ALU_LAT;
- enter EXE.
REQ-016 ALU_OP1, ALU_OP2 and ALU_Code SHALL hold their values from the DECODE exit until the next DECODE exit.
REQ-017 EXE SHALL stay exactly ALU_LAT cycles, then enter WB with WRITE=1.
REQ-018 WB SHALL hold WRITE=1 until RF_ACK=1 is sampled. It SHALL then clear WRITE, pulse INSTR_DONE for one cycle, and return to FETCH.
REQ-019 Timeout: if RF_ACK stays low for ACK_TIMEOUT consecutive cycles in DECODE or WB, the block SHALL:
- clear READ and WRITE;
- pulse TIMEOUT;
- return to FETCH with no INSTR_DONE.
REQ-020 RF_ACK sampled in FETCH, IDLE or EXE SHALL be ignored.
REQ-021 ENABLE SHALL be sampled only in FETCH and IDLE; an instruction already in flight SHALL complete.
REQ-022 READ and WRITE SHALL never be 1 in the same cycle.
REQ-023 Minimum instruction latency (acceptance to INSTR_DONE) SHALL be ALU_LAT+3 cycles when RF_ACK is returned immediately.

Reset
REQ-024 When RST=0 at a CLK rising edge, the block SHALL enter FETCH and clear all of the following to 0:
- READ, WRITE, INSTR_DONE, ILLEGAL, TIMEOUT, BUSY;
- ALU_OP1, ALU_OP2, ALU_Code;
- all counters.
REQ-025 Reset asserted in any state mid-instruction SHALL abort it with no INSTR_DONE, WRITE or TIMEOUT pulse.

Structure
REQ-026 A shared package proc_ctrl_pkg SHALL hold the state encoding, opcode constants, Funct constants, NOP=63 and the ALU code mapping.
REQ-027 Combinational decode SHALL live in sub-module op_decoder. It SHALL output ALU_Code, the immediate-select, the shamt-select, sign/zero extension and the legal flag.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Legality: addi with DATA_R1=5, Imm=0xFFFF, ALU_LAT=1, immediate ACK -> ALU_Code=0x20, ALU_OP2=0xFFFFFFFF, INSTR_DONE 4 cycles after acceptance.
- Shift: R-type sll with Shamt=7 -> ALU_OP2=7, ALU_OP1=DATA_R1.
- NOP: OpCode=63 -> INSTR_DONE pulse, READ stays 0, no state change. OpCode=0x23 -> ILLEGAL pulse, no READ.
- Timeout: RF_ACK held low in DECODE, ACK_TIMEOUT=64 -> TIMEOUT pulse after 64 cycles, READ=0, state FETCH.
- Reset abort: RST=0 during WB with WRITE=1 -> next edge WRITE=0, all outputs 0, no INSTR_DONE.
- Back-to-back and ENABLE: delayed ACK (3 cycles) in DECODE and WB; ENABLE dropped mid-instruction -> instruction completes, then IDLE.
